// File: rtl/stoch_decode_mat_if.sv
// stoch_decode_mat_if: start/busy/valid handshake and bitstream/result bus for the stochastic decoder
interface stoch_decode_mat_if #(
    parameter int COUNTER_SIZE = 10,
    parameter int NUM_ROWS     = 2,
    parameter int NUM_COLS     = 2
);
    localparam int N  = NUM_ROWS * NUM_COLS;
    localparam int CW = COUNTER_SIZE + 1;
    logic          start;
    logic [N-1:0]  Y;
    logic          busy;
    logic          valid;
    logic [N*CW-1:0] data_out;
    modport master (output start, Y, input busy, valid, data_out);
    modport slave  (input start, Y, output busy, valid, data_out);
endinterface

// File: rtl/stoch_decode_mat.sv
// stoch_decode_mat: counts ones per matrix element over a 2^COUNTER_SIZE window
module stoch_decode_mat #(
    parameter int COUNTER_SIZE = 10,
    parameter int NUM_ROWS     = 2,
    parameter int NUM_COLS     = 2
) (
    input logic               CLK,
    input logic               nRST,
    stoch_decode_mat_if.slave bus
);
    localparam int N  = NUM_ROWS * NUM_COLS;
    localparam int CW = COUNTER_SIZE + 1;
    typedef enum logic {IDLE, COUNT} state_t;
    state_t                  state;
    logic [COUNTER_SIZE-1:0] win;
    logic [CW-1:0]           cnt [N];
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state        <= IDLE;
            bus.busy     <= 1'b0;
            bus.valid    <= 1'b0;
            bus.data_out <= '0;
            win          <= '0;
            for (int k = 0; k < N; k++) cnt[k] <= '0;
        end else begin
            bus.valid <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    state    <= COUNT;
                    bus.busy <= 1'b1;
                    win      <= '0;
                    for (int k = 0; k < N; k++) cnt[k] <= '0;
                end
                COUNT: if (win == {COUNTER_SIZE{1'b1}}) begin
                    // last sample folds straight into the result; counters are W+1 wide so all-ones never wraps
                    for (int k = 0; k < N; k++) begin
                        bus.data_out[k*CW +: CW] <= cnt[k] + CW'(bus.Y[k]);
                        cnt[k] <= '0;
                    end
                    bus.valid <= 1'b1;
                    win       <= '0;
                    state     <= bus.start ? COUNT : IDLE;
                    bus.busy  <= bus.start;
                end else begin
                    for (int k = 0; k < N; k++) cnt[k] <= cnt[k] + CW'(bus.Y[k]);
                    win <= win + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stoch_decode_mat.sv
// tb_stoch_decode_mat: directed checks of the decoder with W=16 on a 2x2 matrix
module tb_stoch_decode_mat;
    localparam int CS = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [4:0] el [4];

    stoch_decode_mat_if #(.COUNTER_SIZE(CS)) bus ();
    stoch_decode_mat #(.COUNTER_SIZE(CS)) dut (.CLK(clk), .nRST(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always_comb for (int k = 0; k < 4; k++) el[k] = bus.data_out[k*5 +: 5];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.start = 1'($urandom_range(0, 1));
            bus.Y = 4'($urandom_range(0, 15));
            step;
        end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
        checks++; if (bus.data_out !== 20'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", bus.data_out); end
        bus.start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            bus.Y = 4'($urandom_range(0, 15));
            step;
            checks++;
            if ({bus.busy, bus.valid, bus.data_out} !== 22'h0) begin
                failures++;
                $display("FAIL post_reset_idle cycle %0d: got busy=%b valid=%b data=%h expected all 0", i, bus.busy, bus.valid, bus.data_out);
            end
        end
    endtask

    task automatic test_extremes;
        logic [19:0] held;
        bus.Y = 4'b0101;
        bus.start = 1'b1;
        step;
        bus.start = 1'b0;
        for (int s = 1; s <= 16; s++) begin
            step;
            checks++;
            if (bus.valid !== (s == 16) || bus.busy !== (s < 16)) begin
                failures++;
                $display("FAIL ext_timing t+%0d: got valid=%b busy=%b expected valid=%b busy=%b", s + 1, bus.valid, bus.busy, s == 16, s < 16);
            end
        end
        checks++; if (el[0] !== 5'd16) begin failures++; $display("FAIL ext_el0: got %0d expected 16", el[0]); end
        checks++; if (el[1] !== 5'd0) begin failures++; $display("FAIL ext_el1: got %0d expected 0", el[1]); end
        checks++; if (el[2] !== 5'd16) begin failures++; $display("FAIL ext_el2: got %0d expected 16", el[2]); end
        checks++; if (el[3] !== 5'd0) begin failures++; $display("FAIL ext_el3: got %0d expected 0", el[3]); end
        held = {5'd0, 5'd16, 5'd0, 5'd16};
        for (int i = 0; i < 20; i++) begin
            bus.Y = 4'($urandom_range(0, 15));
            step;
            checks++;
            if (bus.data_out !== held || bus.valid !== 1'b0) begin
                failures++;
                $display("FAIL ext_hold cycle %0d: got data=%h valid=%b expected data=%h valid=0", i, bus.data_out, bus.valid, held);
            end
        end
    endtask

    task automatic test_density;
        int pulses = 0;
        bus.start = 1'b1;
        step;
        bus.start = 1'b0;
        for (int s = 0; s < 16; s++) begin
            bus.Y = {(s % 4) != 0, 2'b00, (s % 4) == 0};
            step;
            pulses += int'(bus.valid);
        end
        checks++; if (el[0] !== 5'd4) begin failures++; $display("FAIL dens_el0: got %0d expected 4", el[0]); end
        checks++; if (el[3] !== 5'd12) begin failures++; $display("FAIL dens_el3: got %0d expected 12", el[3]); end
        checks++; if (el[1] !== 5'd0 || el[2] !== 5'd0) begin failures++; $display("FAIL dens_el12: got %0d/%0d expected 0/0", el[1], el[2]); end
        for (int i = 0; i < 5; i++) begin
            step;
            pulses += int'(bus.valid);
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL dens_pulses: got %0d expected 1", pulses); end
    endtask

    task automatic test_back_to_back;
        logic [4:0] exp_cnt [3] = '{5'd16, 5'd8, 5'd0};
        bus.Y = 4'b0000;
        bus.start = 1'b1;
        step;
        for (int w = 0; w < 3; w++) begin
            for (int s = 0; s < 16; s++) begin
                bus.Y = {3'b000, w == 0 ? 1'b1 : w == 1 ? 1'(s % 2 == 0) : 1'b0};
                if (w == 2 && s == 15) bus.start = 1'b0;
                step;
                checks++;
                if (bus.valid !== (s == 15) || bus.busy !== !(w == 2 && s == 15)) begin
                    failures++;
                    $display("FAIL b2b_timing w%0d s%0d: got valid=%b busy=%b expected valid=%b busy=%b", w, s, bus.valid, bus.busy, s == 15, !(w == 2 && s == 15));
                end
            end
            checks++;
            if (el[0] !== exp_cnt[w]) begin failures++; $display("FAIL b2b_count w%0d: got %0d expected %0d", w, el[0], exp_cnt[w]); end
        end
    endtask

    task automatic test_ignored_start;
        int pulses = 0;
        bus.Y = 4'b1111;
        bus.start = 1'b1;
        step;
        for (int s = 1; s <= 16; s++) begin
            bus.start = (s == 5 || s == 10);
            step;
            checks++;
            if (bus.valid !== (s == 16) || bus.busy !== (s < 16)) begin
                failures++;
                $display("FAIL ign_timing t+%0d: got valid=%b busy=%b expected valid=%b busy=%b", s + 1, bus.valid, bus.busy, s == 16, s < 16);
            end
        end
        bus.start = 1'b0;
        checks++; if (el[1] !== 5'd16) begin failures++; $display("FAIL ign_count: got %0d expected 16", el[1]); end
        for (int i = 0; i < 20; i++) begin
            step;
            pulses += int'(bus.valid) + int'(bus.busy);
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL ign_extra: got %0d busy/valid cycles expected 0", pulses); end
    endtask

    task automatic test_midreset;
        int bad = 0;
        bus.Y = 4'b1111;
        bus.start = 1'b1;
        step;
        bus.start = 1'b0;
        for (int s = 1; s < 8; s++) step;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.valid, bus.data_out} !== 22'h0) begin
            failures++;
            $display("FAIL mid_async: got busy=%b valid=%b data=%h expected all 0", bus.busy, bus.valid, bus.data_out);
        end
        step;
        step;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step;
            bad += int'(bus.valid) + int'(bus.busy) + int'(bus.data_out != 0);
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL mid_abort: got %0d nonzero output cycles expected 0", bad); end
        bus.start = 1'b1;
        step;
        bus.start = 1'b0;
        for (int s = 0; s < 16; s++) begin
            bus.Y = {2'b00, 1'b1, 1'(s < 5)};
            step;
        end
        checks++; if (bus.valid !== 1'b1) begin failures++; $display("FAIL mid_valid: got %b expected 1", bus.valid); end
        checks++; if (el[0] !== 5'd5) begin failures++; $display("FAIL mid_el0: got %0d expected 5", el[0]); end
        checks++; if (el[1] !== 5'd16) begin failures++; $display("FAIL mid_el1: got %0d expected 16", el[1]); end
        checks++; if (el[2] !== 5'd0 || el[3] !== 5'd0) begin failures++; $display("FAIL mid_el23: got %0d/%0d expected 0/0", el[2], el[3]); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.Y = 4'b0000;
        test_reset;
        test_extremes;
        test_density;
        test_back_to_back;
        test_ignored_start;
        test_midreset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
